// File: rtl/ahb_default_slave_cfg_if.sv
// AHB slave-side bus bundle for the default slave.
// Master drives address/control; slave returns ready/response/data.
interface ahb_default_slave_cfg_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HTRANS, HREADY, HADDR, HWRITE,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HTRANS, HREADY, HADDR, HWRITE,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_default_slave_cfg.sv
// AHB default slave: configurable wait states, ERROR or OKAY-RAZ/WI
// response, and a sticky log of the first unmapped access.
module ahb_default_slave_cfg #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    WAIT_STATES = 0,
  parameter int                    RESP_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] RDATA_VALUE = '0,
  parameter int                    CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_default_slave_cfg_if.slave bus,
  input  logic                  ERR_CLEAR,
  output logic                  ERR_VALID,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic                  ERR_WRITE,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("WAIT_STATES must be in 0..15");
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       take;
  logic       unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  // Only address phases seen while we can take a transfer count.
  assign take = accept &
    ((state == ST_IDLE) | (state == ST_ERR2));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS_LOAD;
          end else if (RESP_MODE == 0) begin
            state_nxt = ST_ERR1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = (RESP_MODE == 0) ? ST_ERR1 : ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'b00;
    unique case (state)
      ST_IDLE: begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 2'b00;
      end
      ST_WAIT: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b00;
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b01;
      end
      ST_ERR2: begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 2'b01;
      end
      default: begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 2'b00;
      end
    endcase
  end

  assign bus.HRDATA = RDATA_VALUE;

  // A clear in the same cycle as a new access restarts the log from it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
      ERR_WRITE <= 1'b0;
      ERR_COUNT <= '0;
    end else if (take) begin
      ERR_VALID <= 1'b1;
      if (ERR_CLEAR) begin
        ERR_COUNT <= CNT_WIDTH'(1);
      end else if (ERR_COUNT != '1) begin
        ERR_COUNT <= ERR_COUNT + CNT_WIDTH'(1);
      end
      if (!ERR_VALID || ERR_CLEAR) begin
        ERR_ADDR  <= bus.HADDR;
        ERR_WRITE <= bus.HWRITE;
      end
    end else if (ERR_CLEAR) begin
      ERR_VALID <= 1'b0;
      ERR_COUNT <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// Directed bench for the AHB default slave across three configurations.
// Each step drives after the edge and checks registered outputs 1ns later.
module tb_ahb_default_slave_cfg;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if ();
  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_if ();
  ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) c_if ();

  logic        a_clr, b_clr, c_clr;
  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_addr, b_addr, c_addr;
  logic        a_wr, b_wr, c_wr;
  logic [1:0]  a_cnt;
  logic [7:0]  b_cnt, c_cnt;

  ahb_default_slave_cfg #(
    .WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(2)
  ) u_a (
    .HCLK(HCLK), .HRESET(HRESET), .bus(a_if.slave),
    .ERR_CLEAR(a_clr), .ERR_VALID(a_vld), .ERR_ADDR(a_addr),
    .ERR_WRITE(a_wr), .ERR_COUNT(a_cnt)
  );

  ahb_default_slave_cfg #(
    .WAIT_STATES(3), .RESP_MODE(0)
  ) u_b (
    .HCLK(HCLK), .HRESET(HRESET), .bus(b_if.slave),
    .ERR_CLEAR(b_clr), .ERR_VALID(b_vld), .ERR_ADDR(b_addr),
    .ERR_WRITE(b_wr), .ERR_COUNT(b_cnt)
  );

  ahb_default_slave_cfg #(
    .WAIT_STATES(2), .RESP_MODE(1), .RDATA_VALUE(32'hDEAD_BEEF)
  ) u_c (
    .HCLK(HCLK), .HRESET(HRESET), .bus(c_if.slave),
    .ERR_CLEAR(c_clr), .ERR_VALID(c_vld), .ERR_ADDR(c_addr),
    .ERR_WRITE(c_wr), .ERR_COUNT(c_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic rdy,
                       input logic [1:0] resp);
    chk({tag, ".rdy"}, 64'(a_if.HREADYOUT), 64'(rdy));
    chk({tag, ".resp"}, 64'(a_if.HRESP), 64'(resp));
  endtask

  task automatic chk_b(input string tag, input logic rdy,
                       input logic [1:0] resp);
    chk({tag, ".rdy"}, 64'(b_if.HREADYOUT), 64'(rdy));
    chk({tag, ".resp"}, 64'(b_if.HRESP), 64'(resp));
  endtask

  task automatic chk_c(input string tag, input logic rdy,
                       input logic [1:0] resp);
    chk({tag, ".rdy"}, 64'(c_if.HREADYOUT), 64'(rdy));
    chk({tag, ".resp"}, 64'(c_if.HRESP), 64'(resp));
  endtask

  initial begin
    a_if.HSEL = 0; a_if.HTRANS = 0; a_if.HREADY = 1;
    a_if.HADDR = 0; a_if.HWRITE = 0;
    b_if.HSEL = 0; b_if.HTRANS = 0; b_if.HREADY = 1;
    b_if.HADDR = 0; b_if.HWRITE = 0;
    c_if.HSEL = 0; c_if.HTRANS = 0; c_if.HREADY = 1;
    c_if.HADDR = 0; c_if.HWRITE = 0;
    a_clr = 0; b_clr = 0; c_clr = 0;

    tick(); tick();
    HRESET = 0;
    tick();
    chk_a("rst", 1'b1, 2'b00);
    chk("rst.vld", 64'(a_vld), 64'(0));
    chk("rst.cnt", 64'(a_cnt), 64'(0));
    chk("rst.addr", 64'(a_addr), 64'(0));
    chk("rst.wr", 64'(a_wr), 64'(0));

    // zero-wait ERROR read
    a_if.HSEL = 1; a_if.HTRANS = 2'b10;
    a_if.HADDR = 32'h4000_0000; a_if.HWRITE = 0;
    tick();
    a_if.HSEL = 0; a_if.HTRANS = 0;
    chk_a("e1.err1", 1'b0, 2'b01);
    chk("e1.vld", 64'(a_vld), 64'(1));
    chk("e1.addr", 64'(a_addr), 64'h4000_0000);
    chk("e1.wr", 64'(a_wr), 64'(0));
    chk("e1.cnt", 64'(a_cnt), 64'(1));
    tick();
    chk_a("e1.err2", 1'b1, 2'b01);
    tick();
    chk_a("e1.idle", 1'b1, 2'b00);

    // IDLE, BUSY, and NONSEQ with HREADY low are not accepted
    a_if.HSEL = 1; a_if.HTRANS = 2'b00;
    tick();
    chk_a("idle", 1'b1, 2'b00);
    a_if.HTRANS = 2'b01;
    tick();
    chk_a("busy", 1'b1, 2'b00);
    a_if.HTRANS = 2'b10; a_if.HREADY = 0;
    tick();
    chk_a("nordy", 1'b1, 2'b00);
    chk("nordy.cnt", 64'(a_cnt), 64'(1));
    a_if.HSEL = 0; a_if.HTRANS = 0; a_if.HREADY = 1;

    // three wait states, then back-to-back second error
    b_if.HSEL = 1; b_if.HTRANS = 2'b10;
    b_if.HADDR = 32'h0000_0100; b_if.HWRITE = 1;
    tick();
    b_if.HSEL = 0; b_if.HTRANS = 0;
    chk_b("w.w0", 1'b0, 2'b00);
    chk("w.cnt1", 64'(b_cnt), 64'(1));
    chk("w.wr", 64'(b_wr), 64'(1));
    tick();
    chk_b("w.w1", 1'b0, 2'b00);
    tick();
    chk_b("w.w2", 1'b0, 2'b00);
    tick();
    chk_b("w.err1", 1'b0, 2'b01);
    tick();
    chk_b("w.err2", 1'b1, 2'b01);
    b_if.HSEL = 1; b_if.HTRANS = 2'b10;
    b_if.HADDR = 32'h0000_0200; b_if.HWRITE = 0;
    tick();
    b_if.HSEL = 0; b_if.HTRANS = 0;
    chk_b("w.b2b", 1'b0, 2'b00);
    chk("w.cnt2", 64'(b_cnt), 64'(2));
    chk("w.addr", 64'(b_addr), 64'h0000_0100);
    chk("w.wr2", 64'(b_wr), 64'(1));

    // OKAY mode with two wait states
    c_if.HSEL = 1; c_if.HTRANS = 2'b10;
    c_if.HADDR = 32'h0000_0300; c_if.HWRITE = 0;
    tick();
    c_if.HSEL = 0; c_if.HTRANS = 0;
    chk_c("ok.w0", 1'b0, 2'b00);
    chk("ok.cnt", 64'(c_cnt), 64'(1));
    tick();
    chk_c("ok.w1", 1'b0, 2'b00);
    tick();
    chk_c("ok.done", 1'b1, 2'b00);
    chk("ok.data", 64'(c_if.HRDATA), 64'hDEAD_BEEF);
    tick();
    chk_c("ok.idle", 1'b1, 2'b00);

    // clear, then saturate a 2-bit counter
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("clr.vld", 64'(a_vld), 64'(0));
    chk("clr.cnt", 64'(a_cnt), 64'(0));
    chk("clr.addr", 64'(a_addr), 64'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      a_if.HSEL = 1; a_if.HTRANS = 2'b10;
      a_if.HADDR = 32'h10 + 32'(i); a_if.HWRITE = 0;
      tick();
      a_if.HSEL = 0; a_if.HTRANS = 0;
      tick(); tick();
    end
    chk("sat.cnt", 64'(a_cnt), 64'(3));
    chk("sat.addr", 64'(a_addr), 64'h10);
    chk("sat.vld", 64'(a_vld), 64'(1));

    // clear coincident with an accept: accept wins
    a_if.HSEL = 1; a_if.HTRANS = 2'b10;
    a_if.HADDR = 32'h8; a_if.HWRITE = 1; a_clr = 1;
    tick();
    a_if.HSEL = 0; a_if.HTRANS = 0; a_clr = 0;
    chk("cc.cnt", 64'(a_cnt), 64'(1));
    chk("cc.addr", 64'(a_addr), 64'h8);
    chk("cc.vld", 64'(a_vld), 64'(1));
    chk("cc.wr", 64'(a_wr), 64'(1));
    chk_a("cc.err1", 1'b0, 2'b01);

    // asynchronous reset during ERR1
    #2 HRESET = 1;
    #1;
    chk_a("arst", 1'b1, 2'b00);
    chk("arst.vld", 64'(a_vld), 64'(0));
    chk("arst.cnt", 64'(a_cnt), 64'(0));
    chk("arst.addr", 64'(a_addr), 64'(0));
    tick();
    HRESET = 0;
    a_if.HSEL = 1; a_if.HTRANS = 2'b11;
    a_if.HADDR = 32'h500; a_if.HWRITE = 0;
    tick();
    a_if.HSEL = 0; a_if.HTRANS = 0;
    chk_a("post.err1", 1'b0, 2'b01);
    chk("post.cnt", 64'(a_cnt), 64'(1));
    chk("post.addr", 64'(a_addr), 64'h500);
    tick();
    chk_a("post.err2", 1'b1, 2'b01);
    tick();
    chk_a("post.idle", 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave_cfg.md
Name: ahb_default_slave_cfg

Overview:
Parametrised AHB default slave for the bus-matrix output stage. It answers every transfer that decodes to no mapped slave. It supports configurable wait states and two response modes: an AHB two-cycle ERROR, or an OKAY read-as-zero / write-ignore. It also keeps a software-visible log of unmapped accesses: first offending address and direction, plus a saturating access count.

Parameters:
ADDR_WIDTH, 32, width of HADDR and ERR_ADDR
DATA_WIDTH, 32, width of HRDATA
WAIT_STATES, 0, HREADYOUT-low cycles inserted before the response phase; legal range 0..15
RESP_MODE, 0, 0 = two-cycle ERROR response; 1 = OKAY with RDATA_VALUE on reads, writes discarded
RDATA_VALUE, 0, constant driven on HRDATA (DATA_WIDTH bits)
CNT_WIDTH, 8, width of ERR_COUNT

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  asynchronous reset, active-high
HSEL  in  1  default-slave select
HTRANS  in  2  transfer type
HREADY  in  1  bus ready (transfer-done) input
HADDR  in  ADDR_WIDTH  transfer address
HWRITE  in  1  transfer direction
HREADYOUT  out  1  slave ready
HRESP  out  2  response: 2'b00 OKAY, 2'b01 ERROR
HRDATA  out  DATA_WIDTH  read data, constant RDATA_VALUE
ERR_CLEAR  in  1  synchronous clear of the log, one-cycle pulse
ERR_VALID  out  1  sticky: at least one unmapped access logged
ERR_ADDR  out  ADDR_WIDTH  HADDR of the first logged access
ERR_WRITE  out  1  HWRITE of the first logged access
ERR_COUNT  out  CNT_WIDTH  saturating count of logged accesses

Behaviour:
- Reset (HRESET high, asynchronous):
  - state = ST_IDLE, HREADYOUT = 1, HRESP = OKAY.
  - Wait counter = 0, ERR_VALID = 0, ERR_ADDR = 0, ERR_WRITE = 0, ERR_COUNT = 0.
  - Reset mid-transfer aborts the response immediately; no partial log update.
- accept = HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ), sampled on the rising HCLK edge.
- IDLE/BUSY or unselected transfers get a zero-wait OKAY and are not logged.
- States and outputs:
  - ST_IDLE: HREADYOUT = 1, HRESP = OKAY.
  - ST_WAIT: HREADYOUT = 0, HRESP = OKAY.
  - ST_ERR1: HREADYOUT = 0, HRESP = ERROR.
  - ST_ERR2: HREADYOUT = 1, HRESP = ERROR.
- Transitions from ST_IDLE or ST_ERR2 on accept:
  - WAIT_STATES > 0: go to ST_WAIT, counter loaded with WAIT_STATES-1.
  - WAIT_STATES = 0, RESP_MODE = 0: go to ST_ERR1.
  - WAIT_STATES = 0, RESP_MODE = 1: go to (or stay in) ST_IDLE, i.e. a zero-wait OKAY.
- ST_IDLE / ST_ERR2 with no accept: go to ST_IDLE.
- ST_WAIT: decrement the counter each cycle. At counter = 0, go to ST_ERR1 if RESP_MODE = 0, else ST_IDLE (OKAY completion). HSEL/HTRANS are ignored while in ST_WAIT.
- ST_ERR1 always goes to ST_ERR2.
- A new accept in ST_ERR2 (HREADY high at the end of the error) is honoured back-to-back. Each error therefore occupies exactly 2 response cycles.
- Data-phase length after accept:
  - RESP_MODE 0: WAIT_STATES + 2 cycles.
  - RESP_MODE 1: WAIT_STATES + 1 cycles.
- HRDATA = RDATA_VALUE in all states. Write data is never stored.
- Log, updated on the accept edge in both modes:
  - ERR_COUNT increments, saturating at all-ones.
  - If ERR_VALID = 0: capture HADDR into ERR_ADDR, HWRITE into ERR_WRITE, and set ERR_VALID.
  - Later accesses do not overwrite ERR_ADDR / ERR_WRITE.
- ERR_CLEAR sets ERR_VALID = 0 and ERR_COUNT = 0; ERR_ADDR / ERR_WRITE are held.
- ERR_CLEAR in the same cycle as an accept: the accept wins. Result is ERR_COUNT = 1, ERR_VALID = 1, and ERR_ADDR / ERR_WRITE take the new transfer.
- WAIT_STATES outside 0..15 is a configuration error (simulation $error). The counter is 4 bits.

Test Plan:
- RESP_MODE=0, WAIT_STATES=0: NONSEQ read to 0x4000_0000 with HSEL=1. Expect next cycle HREADYOUT=0/HRESP=01, then 1/01, then 1/00. ERR_VALID=1, ERR_ADDR=0x4000_0000, ERR_WRITE=0, ERR_COUNT=1.
- RESP_MODE=0, WAIT_STATES=3: a single write. Expect 3 cycles of HREADYOUT=0/HRESP=00, then ERR1, then ERR2. A second NONSEQ presented during ERR2 starts a new wait sequence immediately; ERR_COUNT=2 and ERR_ADDR unchanged.
- RESP_MODE=1, WAIT_STATES=2, RDATA_VALUE=0xDEAD_BEEF: a read. Expect 2 low cycles, then HREADYOUT=1, HRESP=00, HRDATA=0xDEAD_BEEF. HRESP is never 01.
- IDLE and BUSY with HSEL=1, plus NONSEQ with HREADY=0: HREADYOUT stays 1, HRESP=00, ERR_COUNT unchanged.
- CNT_WIDTH=2: 5 accepted errors give ERR_COUNT=3 (saturated). ERR_CLEAR together with a 6th accept to 0x8 gives ERR_COUNT=1, ERR_ADDR=0x8, ERR_VALID=1.
- Assert HRESET asynchronously during ST_ERR1: outputs immediately HREADYOUT=1, HRESP=00, log cleared. The next NONSEQ produces a full, correct error sequence.
